// File: rtl/e_mdu_ctrl_if.sv
// E-stage multiply/divide bus: decode-side request fields plus the unit's
// status, HI/LO registers and mfhi/mflo read data.
interface e_mdu_ctrl_if;
  logic [3:0]  MDOp;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        D_is_md;
  logic        Busy;
  logic        Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_out;

  modport master (
    output MDOp, Start, A, B, D_is_md,
    input  Busy, Stall_MD, HI, LO, MD_out
  );

  modport slave (
    input  MDOp, Start, A, B, D_is_md,
    output Busy, Stall_MD, HI, LO, MD_out
  );
endinterface

// File: rtl/e_mdu_ctrl.sv
// Multiply/divide unit for the E stage: computes the result at accept time,
// holds it for a fixed busy period, then commits it to HI/LO.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          Clk,
  input logic          Rst,
  e_mdu_ctrl_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  logic [CW-1:0] counter;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_valid;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   b_mag_safe;
  logic [31:0]   b_safe;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   q_s;
  logic [31:0]   r_s;
  logic [31:0]   q_u;
  logic [31:0]   r_u;

  logic          calc_start;
  logic [CW-1:0] calc_cycles;
  logic [31:0]   calc_hi;
  logic [31:0]   calc_lo;
  logic          calc_valid;
  logic          busy;

  assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
  assign prod_u = {32'b0, md.A} * {32'b0, md.B};

  // Signed divide works on magnitudes so the 0x80000000 / -1 overflow case
  // naturally wraps to 0x80000000 with a zero remainder.
  assign a_neg      = md.A[31];
  assign b_neg      = md.B[31];
  assign a_mag      = a_neg ? (32'd0 - md.A) : md.A;
  assign b_mag      = b_neg ? (32'd0 - md.B) : md.B;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (md.B == 32'd0) ? 32'd1 : md.B;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign q_s        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s        = a_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u        = md.A / b_safe;
  assign r_u        = md.A % b_safe;

  always_comb begin
    calc_start  = 1'b0;
    calc_cycles = '0;
    calc_hi     = 32'd0;
    calc_lo     = 32'd0;
    calc_valid  = 1'b1;
    case (md.MDOp)
      OP_MULT: begin
        calc_start  = md.Start;
        calc_cycles = CW'(MULT_CYCLES);
        calc_hi     = prod_s[63:32];
        calc_lo     = prod_s[31:0];
      end
      OP_MULTU: begin
        calc_start  = md.Start;
        calc_cycles = CW'(MULT_CYCLES);
        calc_hi     = prod_u[63:32];
        calc_lo     = prod_u[31:0];
      end
      OP_DIV: begin
        calc_start  = md.Start;
        calc_cycles = CW'(DIV_CYCLES);
        calc_hi     = r_s;
        calc_lo     = q_s;
        calc_valid  = (md.B != 32'd0);
      end
      OP_DIVU: begin
        calc_start  = md.Start;
        calc_cycles = CW'(DIV_CYCLES);
        calc_hi     = r_u;
        calc_lo     = q_u;
        calc_valid  = (md.B != 32'd0);
      end
      default: ;
    endcase
  end

  assign busy = (counter != '0);

  // Busy blocks new starts and mthi/mtlo; the last countdown edge commits.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      counter    <= '0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
    end else if (busy) begin
      counter <= counter - 1'b1;
      if (counter == CW'(1) && pend_valid) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (calc_start) begin
      counter    <= calc_cycles;
      pend_hi    <= calc_hi;
      pend_lo    <= calc_lo;
      pend_valid <= calc_valid;
    end else if (!md.Start && md.MDOp == OP_MTHI) begin
      hi <= md.A;
    end else if (!md.Start && md.MDOp == OP_MTLO) begin
      lo <= md.A;
    end
  end

  always_comb begin
    md.MD_out = 32'd0;
    if (md.MDOp == OP_MFHI) md.MD_out = hi;
    else if (md.MDOp == OP_MFLO) md.MD_out = lo;
  end

  assign md.Busy     = busy;
  assign md.Stall_MD = md.D_is_md & (md.Start | busy);
  assign md.HI       = hi;
  assign md.LO       = lo;

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multiply/divide unit with its sequencing controller, placed in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E-stage decode and models the multi-cycle latency with a busy counter.
- Holds the HI/LO architectural registers.
- Generates the MD stall request consumed by the hazard unit, so the D stage holds md-class instructions while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  synchronous active-high reset; the caller ORs in flush sources
- MDOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none
- Start  input  1  one-cycle pulse from E decode, high only with MDOp 1..4
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- D_is_md  input  1  D-stage instruction is any md-class op (1..8)
- Busy  output  1  operation in flight
- Stall_MD  output  1  stall request to hazard unit
- HI  output  32  HI register
- LO  output  32  LO register
- MD_out  output  32  mfhi → HI, mflo → LO, else 0; combinational

Behaviour:
- Reset (Rst high at an edge): HI=0, LO=0, Busy=0, counter=0, pending result discarded. Applies even mid-operation; no commit occurs on that edge.
- Internal state:
  - counter, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1))
  - pend_hi/pend_lo, 32 bits each
  - pend_valid, 1 bit (suppresses commit on divide-by-zero)
- Busy = (counter != 0), registered-derived, no combinational path from inputs.
- Stall_MD = D_is_md & (Start | Busy), combinational.
- Accept rule: at an edge with Start=1 and Busy=0 and Rst=0:
  - mult/multu: counter ← MULT_CYCLES.
  - div/divu: counter ← DIV_CYCLES.
  - pend_hi/pend_lo computed from A,B at the same edge.
- Start while Busy=1 is ignored entirely. The hazard unit makes this impossible; the bench flags it as a protocol violation.
- Timing: Start in cycle t → Busy=1 in cycles t+1 .. t+N.
  - counter decrements each edge while nonzero.
  - On the edge where counter goes 1→0 and pend_valid=1, HI←pend_hi and LO←pend_lo. New values are visible in cycle t+N+1, the same cycle Busy falls.
- Arithmetic:
  - mult: signed 32x32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32→64; HI=[63:32], LO=[31:0].
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B=0, div or divu): pend_valid=0, full DIV_CYCLES busy period still runs, HI/LO unchanged at completion.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: with Busy=0 and Start=0, HI←A (mthi) or LO←A (mtlo) at the edge, one cycle, no busy period. Ignored while Busy=1.
- mfhi/mflo: MD_out reflects the current HI/LO. The hazard unit prevents reads while Busy. mfhi/mflo in cycle t+N+1 reads the committed result.
- Simultaneous events:
  - Rst dominates all.
  - Commit edge coincident with a Start is impossible, because Busy=1 blocks it.
  - mthi/mtlo coincident with completion is impossible under stall.
- Back-to-back ops: a new Start is permitted in cycle t+N+1 onward.
- Total latency is exactly N+1 edges from Start to readable result; no early termination.

Test Plan:
- mult A=0xFFFFFFFD (−3), B=5; Start in cycle 0 → Busy=1 cycles 1..5, HI=0xFFFFFFFF and LO=0xFFFFFFF1 visible cycle 6; Busy=0 cycle 6.
- multu A=0xFFFFFFFF, B=2, then mflo in cycle 6 → HI=0x00000001, MD_out=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → Busy cycles 1..10, LO=0xFFFFFFFD, HI=0xFFFFFFFF at cycle 11.
  - divu A=7, B=2 → LO=3, HI=1.
- divu A=7, B=0 with prior HI=0x11, LO=0x22 → Busy 10 cycles, HI/LO remain 0x11/0x22.
- Stall and ignore: D_is_md=1 during cycles 0..5 of a mult → Stall_MD=1 in cycles 0..5, 0 in cycle 6.
  - mtlo A=0xABCD while Busy → LO unaffected.
  - mtlo A=0xABCD when idle → LO=0xABCD next cycle.
- Reset mid-operation: start div, assert Rst in cycle 4 → cycle 5: Busy=0, HI=LO=0, no later commit; a new mult accepted in cycle 5 completes normally.
